// File: rtl/sub_pkg.sv
// Shared constants and state encoding for the bit-serial subtractor.
package sub_pkg;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/sub_serial_if.sv
// Operand/result handshake bundle between requester and the serial subtractor.
interface sub_serial_if
  import sub_pkg::*;
();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (output start, a, b, bin, input  busy, done, diff, bout, ovf);
  modport slave  (input  start, a, b, bin, output busy, done, diff, bout, ovf);
endinterface

// File: rtl/full_sub1.sv
// Gate-level single-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_sub1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);
endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor: a - b - bin, LSB first through one full-subtractor
// cell, sequenced by a start/busy/done handshake.
module sub_serial
  import sub_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  sub_serial_if.slave  s
);
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_d;
  logic             w_bout;
  logic             w_last;

  full_sub1 u_cell (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // r_br holds the borrow entering the current bit; on the last bit that is
  // the borrow into the MSB, which together with the MSB borrow-out gives ovf.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (s.start) begin
            r_a     <= s.a;
            r_b     <= s.b;
            r_br    <= s.bin;
            r_res   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_bout;
          r_res <= {w_d, r_res[WIDTH-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_diff  <= {w_d, r_res[WIDTH-1:1]};
            r_bout  <= w_bout;
            r_ovf   <= r_br ^ w_bout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign s.busy = r_busy;
  assign s.done = r_done;
  assign s.diff = r_diff;
  assign s.bout = r_bout;
  assign s.ovf  = r_ovf;
endmodule

// File: tb/tb_sub_serial.sv
// Scoreboard bench for sub_serial: stimulus queues expected results, a
// negedge monitor pops and compares on every done pulse.
module tb_sub_serial;
  import sub_pkg::*;

  typedef struct {
    logic [7:0]  d;
    logic        bo;
    logic        ov;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          cont_mode = 1'b0;
  exp_t        q[$];

  sub_serial_if bus ();

  sub_serial dut (
    .clk   (clk),
    .reset (reset),
    .s     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (cont_mode) chk("busy_xor_done", 32'(bus.busy ^ bus.done), 1);
    if (bus.done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("diff", 32'(bus.diff), 32'(e.d));
        chk("bout", 32'(bus.bout), 32'(e.bo));
        chk("ovf", 32'(bus.ovf), 32'(e.ov));
        chk("done_cycle", cyc, e.cyc);
        chk("busy_with_done", 32'(bus.busy), 0);
      end
    end
  end

  // Drives one request; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                          input logic [7:0] ed, input logic eb, input logic eo,
                          input bit expect_it, input bit keep);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bi;
    @(negedge clk);
    if (!keep) begin
      bus.start = 1'b0;
      bus.a     = ~a;
      bus.b     = ~b;
      bus.bin   = ~bi;
    end
    if (expect_it) begin
      e.d = ed; e.bo = eb; e.ov = eo; e.cyc = cyc + 8;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0 && !bus.busy && !bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_timeout", 32'(ok), 1);
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_diff", 32'(bus.diff), 0);
    reset = 1'b0;

    // Basic op with busy-width check
    start_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy) break;
      n++;
      @(negedge clk);
    end
    chk("busy_len", 32'(n), 8);
    drain();

    start_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1, 0);
    drain();
    start_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1, 0);
    drain();
    start_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1, 0);
    drain();
    start_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1, 0);
    drain();

    // Start pulse and input changes during RUN must be ignored
    start_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1, 0);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; bus.bin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.a = 8'h55; bus.b = 8'hAA;
    drain();
    repeat (12) @(negedge clk);

    // Asynchronous reset mid-RUN
    start_op(8'h20, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_diff", 32'(bus.diff), 0);
    chk("abort_bout", 32'(bus.bout), 0);
    chk("abort_ovf", 32'(bus.ovf), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_idle", 32'(bus.busy), 0);
    start_op(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0, 1, 0);
    drain();

    // Start held high: back-to-back ops every 9 cycles
    begin
      exp_t e;
      int seen = 0;
      start_op(8'h0A, 8'h03, 1'b0, 8'h07, 1'b0, 1'b0, 1, 1);
      e.d = 8'h07; e.bo = 1'b0; e.ov = 1'b0;
      e.cyc = cyc + 17; q.push_back(e);
      e.cyc = cyc + 26; q.push_back(e);
      cont_mode = 1'b1;
      for (int i = 0; i < 60; i++) begin
        if (bus.done) seen++;
        if (seen == 3) break;
        @(negedge clk);
      end
      bus.start = 1'b0;
      cont_mode = 1'b0;
      chk("cont_done_count", 32'(seen), 3);
      drain();
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
